// File: rtl/dmx3_reg_pkg.sv
// rtl/dmx3_reg_pkg.sv - shared constants and helpers for the registered 1:3 demux
package dmx3_reg_pkg;

    localparam int         N_CH     = 3;
    localparam logic [1:0] ADR_BAD  = 2'b11;
    localparam logic [1:0] PTR_LAST = 2'd2;

    // Round-robin successor: 0 -> 1 -> 2 -> 0, never producing the illegal address.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/dmx3_slot.sv
// rtl/dmx3_slot.sv - one holding register with valid flag, consumer ack and drop detect
module dmx3_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sel,
    input  logic [W-1:0] din,
    input  logic         ack,
    output logic [W-1:0] y,
    output logic         vld,
    output logic         drop
);

    logic accept;

    // A same-cycle ack frees the slot, so the incoming word is taken rather than dropped.
    assign accept = sel && (!vld || ack);
    assign drop   = sel && vld && !ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y   <= '0;
            vld <= 1'b0;
        end else if (accept) begin
            y   <= din;
            vld <= 1'b1;
        end else if (ack) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/dmx3_reg.sv
// rtl/dmx3_reg.sv - registered 1:3 demux with address or round-robin channel select
module dmx3_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic [1:0]   adr,
    input  logic         we,
    input  logic         scan,
    input  logic [2:0]   ack,
    input  logic         clr,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [2:0]   vld,
    output logic         ovf,
    output logic         err,
    output logic [1:0]   cur_adr
);

    import dmx3_reg_pkg::*;

    logic [1:0]      ptr;
    logic [1:0]      ea;
    logic [N_CH-1:0] sel;
    logic [N_CH-1:0] drop;
    logic [W-1:0]    y_arr [N_CH];

    assign ea = scan ? ptr : adr;

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        assign sel[g] = we && (ea == 2'(g));

        dmx3_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (sel[g]),
            .din   (din),
            .ack   (ack[g]),
            .y     (y_arr[g]),
            .vld   (vld[g]),
            .drop  (drop[g])
        );
    end

    assign y0      = y_arr[0];
    assign y1      = y_arr[1];
    assign y2      = y_arr[2];
    assign cur_adr = ptr;

    // New events take priority over clr so a same-cycle fault is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 2'd0;
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            if (we && scan)
                ptr <= next_ptr(ptr);

            if (|drop)
                ovf <= 1'b1;
            else if (clr)
                ovf <= 1'b0;

            if (we && (ea == ADR_BAD))
                err <= 1'b1;
            else if (clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmx3_reg.sv
// tb/tb_dmx3_reg.sv - self-checking bench for dmx3_reg against a behavioural model
module tb_dmx3_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic [1:0]   adr;
    logic         we;
    logic         scan;
    logic [2:0]   ack;
    logic         clr;
    logic [W-1:0] y0, y1, y2;
    logic [2:0]   vld;
    logic         ovf, err;
    logic [1:0]   cur_adr;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    dmx3_reg #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .adr     (adr),
        .we      (we),
        .scan    (scan),
        .ack     (ack),
        .clr     (clr),
        .y0      (y0),
        .y1      (y1),
        .y2      (y2),
        .vld     (vld),
        .ovf     (ovf),
        .err     (err),
        .cur_adr (cur_adr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Behavioural reference: channel contents as plain arrays, pointer as an integer mod 3.
    logic [W-1:0] m_y [3];
    logic [2:0]   m_v;
    logic         m_ovf, m_err;
    int           m_ptr;

    always @(posedge clk) begin
        int           e;
        logic [W-1:0] ny [3];
        logic [2:0]   nv;
        bit           ev_ovf, ev_err;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_y[i] <= '0;
            m_v   <= 3'b000;
            m_ovf <= 1'b0;
            m_err <= 1'b0;
            m_ptr <= 0;
        end else begin
            ny     = m_y;
            nv     = m_v & ~ack;
            ev_ovf = 0;
            ev_err = 0;
            e      = scan ? m_ptr : int'(adr);
            if (we) begin
                if (e == 3)
                    ev_err = 1;
                else if (m_v[e] && !ack[e])
                    ev_ovf = 1;
                else begin
                    ny[e] = din;
                    nv[e] = 1'b1;
                end
            end
            m_y   <= ny;
            m_v   <= nv;
            m_ovf <= ev_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_err <= ev_err ? 1'b1 : (clr ? 1'b0 : m_err);
            if (we && scan) m_ptr <= (m_ptr + 1) % 3;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_y0", 32'(y0), 32'(m_y[0]));
            chk("model_y1", 32'(y1), 32'(m_y[1]));
            chk("model_y2", 32'(y2), 32'(m_y[2]));
            chk("model_vld", 32'(vld), 32'(m_v));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
            chk("model_err", 32'(err), 32'(m_err));
            chk("model_cur_adr", 32'(cur_adr), 32'(m_ptr));
        end
    end

    // Inputs are applied just after a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [W-1:0] d, input logic [1:0] a, input logic w,
                       input logic s, input logic [2:0] k, input logic c);
        din = d; adr = a; we = w; scan = s; ack = k; clr = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; adr = '0; we = 0; scan = 0; ack = '0; clr = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0);
        chk_en = 1;
        rst_n  = 1'b1;
        chk("rst_y0", 32'(y0), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_flags", {30'd0, ovf, err}, 0);
        chk("rst_cur_adr", 32'(cur_adr), 0);

        // addressed fill of all three channels
        cyc(4'h5, 0, 1, 0, 0, 0);
        cyc(4'hA, 1, 1, 0, 0, 0);
        cyc(4'h3, 2, 1, 0, 0, 0);
        chk("t1_y0", 32'(y0), 32'h5);
        chk("t1_y1", 32'(y1), 32'hA);
        chk("t1_y2", 32'(y2), 32'h3);
        chk("t1_vld", 32'(vld), 32'b111);
        chk("t1_flags", {30'd0, ovf, err}, 0);

        // overflow on full channel, then clear
        cyc(4'hF, 1, 1, 0, 0, 0);
        chk("t2_y1_kept", 32'(y1), 32'hA);
        chk("t2_ovf", 32'(ovf), 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t2_ovf_clr", 32'(ovf), 0);

        // same-cycle ack and write: write wins
        cyc(4'h7, 1, 1, 0, 3'b010, 0);
        chk("t3_y1", 32'(y1), 32'h7);
        chk("t3_vld", 32'(vld), 32'b111);
        chk("t3_ovf", 32'(ovf), 0);
        cyc(0, 0, 0, 0, 3'b010, 0);
        chk("t3_vld_ack", 32'(vld), 32'b101);
        chk("t3_y1_hold", 32'(y1), 32'h7);

        // round-robin scan from reset
        do_reset();
        chk("t4_ptr0", 32'(cur_adr), 0);
        cyc(1, 3, 1, 1, 0, 0);
        chk("t4_ptr1", 32'(cur_adr), 1);
        cyc(2, 3, 1, 1, 0, 0);
        chk("t4_ptr2", 32'(cur_adr), 2);
        cyc(3, 3, 1, 1, 0, 0);
        chk("t4_ptr3", 32'(cur_adr), 0);
        chk("t4_ovf_before", 32'(ovf), 0);
        cyc(4, 3, 1, 1, 0, 0);
        chk("t4_ptr4", 32'(cur_adr), 1);
        chk("t4_y012", {20'd0, y0, y1, y2}, 32'h123);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_err", 32'(err), 0);

        // bad address, event beats clr
        cyc(4'h9, 3, 1, 0, 0, 0);
        chk("t5_err", 32'(err), 1);
        chk("t5_vld", 32'(vld), 32'b111);
        chk("t5_y012", {20'd0, y0, y1, y2}, 32'h123);
        cyc(4'h9, 3, 1, 0, 0, 1);
        chk("t5_err_vs_clr", 32'(err), 1);
        chk("t5_ovf_cleared", 32'(ovf), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5_err_clr", 32'(err), 0);

        // reset dominates a concurrent write
        rst_n = 1'b0;
        cyc(4'hC, 2, 1, 0, 3'b111, 1);
        rst_n = 1'b1;
        chk("t6_y2", 32'(y2), 0);
        chk("t6_vld", 32'(vld), 0);
        chk("t6_cur_adr", 32'(cur_adr), 0);

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(W'($urandom), 2'($urandom), ($urandom_range(0, 9) < 7),
                1'($urandom), ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000,
                ($urandom_range(0, 7) == 0));
            rst_n = 1'b1;
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
